control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_pkg.sv | 38 +++
 rtl/control_sequencer_if.sv | 22 ++
 rtl/control_sequencer_dec3to8.sv | 16 +
 rtl/control_sequencer.sv | 110 +++++++++++
 tb/tb_control_sequencer.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared constants for the control sequencer: opcodes, ALU codes,
// bus source codes and the FSM state encoding.
package control_sequencer_pkg;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;

    // ALU opcodes; the ALU operations share encoding with the instruction opcodes.
    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_XOR  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_AND  = 3'b101;

    // Bus source select: 0-7 pick R0-R7.
    localparam logic [3:0] BUS_G   = 4'd8;
    localparam logic [3:0] BUS_DIN = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T1   = 2'd1,
        S_T2   = 2'd2,
        S_T3   = 2'd3
    } state_e;

    function automatic logic [3:0] bus_reg(input logic [2:0] r);
        return {1'b0, r};
    endfunction

    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_XOR) || (op == OP_OR) || (op == OP_AND);
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Handshake and datapath-control bundle between the sequencer and its host.
interface control_sequencer_if;
    logic        run;
    logic [15:0] din;
    logic [3:0]  bus_sel;
    logic [7:0]  reg_we;
    logic        a_load;
    logic        g_load;
    logic [2:0]  alu_op_select;
    logic        done;
    logic        illegal;

    modport master (
        output run, din,
        input  bus_sel, reg_we, a_load, g_load, alu_op_select, done, illegal
    );

    modport slave (
        input  run, din,
        output bus_sel, reg_we, a_load, g_load, alu_op_select, done, illegal
    );
endinterface

// File: rtl/control_sequencer_dec3to8.sv
// 3-bit index to one-hot 8-bit decoder with enable; drives register writes.
module dec3to8 (
    input  logic       en,
    input  logic [2:0] idx,
    output logic [7:0] onehot
);

    // One bit set at idx when enabled, otherwise all zero.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Moore FSM sequencing MV/MVI and two-operand ALU instructions over a shared bus.
//
// state | meaning
// IDLE  | waiting for run; captures din into IR
// T1    | MV/MVI write (done), ALU operand A load, or illegal (done)
// T2    | ALU: second operand on bus, G loaded
// T3    | ALU: G written back to rx (done)
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    control_sequencer_if.slave   bus
);

    localparam logic [1:0] IDLE = S_IDLE;
    localparam logic [1:0] T1   = S_T1;
    localparam logic [1:0] T2   = S_T2;
    localparam logic [1:0] T3   = S_T3;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [15:0] ir;
    logic [2:0]  opcode;
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic        we_en;
    logic [7:0]  reg_we_dec;
    logic        unused_ir;

    assign opcode    = ir[15:13];
    assign rx        = ir[12:10];
    assign ry        = ir[9:7];
    assign unused_ir = ^ir[6:0];

    // Next-state selection; run only matters in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.run ? T1 : IDLE;
            T1:      state_nxt = is_alu_op(opcode) ? T2 : IDLE;
            T2:      state_nxt = T3;
            T3:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State and instruction register; reset wins over a concurrent run.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.run) begin
                ir <= bus.din;
            end
        end
    end

    // Moore outputs decoded from state and IR only.
    always_comb begin
        bus.bus_sel       = 4'd0;
        bus.a_load        = 1'b0;
        bus.g_load        = 1'b0;
        bus.alu_op_select = ALU_PASS;
        bus.done          = 1'b0;
        bus.illegal       = 1'b0;
        we_en             = 1'b0;
        case (state)
            T1: begin
                if (opcode == OP_MV) begin
                    bus.bus_sel = bus_reg(ry);
                    we_en       = 1'b1;
                    bus.done    = 1'b1;
                end else if (opcode == OP_MVI) begin
                    bus.bus_sel = BUS_DIN;
                    we_en       = 1'b1;
                    bus.done    = 1'b1;
                end else if (is_alu_op(opcode)) begin
                    bus.bus_sel = bus_reg(rx);
                    bus.a_load  = 1'b1;
                end else begin
                    bus.done    = 1'b1;
                    bus.illegal = 1'b1;
                end
            end
            T2: begin
                bus.bus_sel       = bus_reg(ry);
                bus.alu_op_select = opcode;
                bus.g_load        = 1'b1;
            end
            T3: begin
                bus.bus_sel = BUS_G;
                we_en       = 1'b1;
                bus.done    = 1'b1;
            end
            default: ;
        endcase
    end

    dec3to8 u_dec3to8 (
        .en     (we_en),
        .idx    (rx),
        .onehot (reg_we_dec)
    );

    assign bus.reg_we = reg_we_dec;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus queues expected output
// vectors, a negedge monitor pops one per non-idle output cycle.
module tb_control_sequencer;
    import control_sequencer_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc;

    logic [18:0] exp_q[$];
    string       name_q[$];
    int          done_cycles[$];

    control_sequencer_if u_if ();

    control_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // {bus_sel, reg_we, a_load, g_load, alu_op_select, done, illegal}
    logic [18:0] obs;
    assign obs = {u_if.bus_sel, u_if.reg_we, u_if.a_load, u_if.g_load,
                  u_if.alu_op_select, u_if.done, u_if.illegal};

    function automatic logic [18:0] pk(input logic [3:0] bs, input logic [7:0] we,
                                       input logic a, input logic g, input logic [2:0] op,
                                       input logic d, input logic il);
        return {bs, we, a, g, op, d, il};
    endfunction

    task automatic expect_out(input string n, input logic [18:0] v);
        exp_q.push_back(v);
        name_q.push_back(n);
    endtask

    task automatic send(input logic [15:0] w, input logic [15:0] opnd, input int idle_after);
        @(posedge clk); #1;
        u_if.run = 1'b1;
        u_if.din = w;
        @(posedge clk); #1;
        u_if.run = 1'b0;
        u_if.din = opnd;
        repeat (idle_after) @(posedge clk);
    endtask

    task automatic check_idle(input string n);
        @(negedge clk);
        total++;
        if (obs !== 19'd0) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", n, obs, 19'd0);
        end
    endtask

    // Monitor: every cycle with any output asserted consumes one expectation.
    always @(negedge clk) begin
        logic [18:0] e;
        string       n;
        if ((|obs) === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output got=%h expected=none", obs);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (obs !== e) begin
                    bad++;
                    $display("FAIL %s got=%h expected=%h", n, obs, e);
                end
            end
            if (u_if.done === 1'b1) done_cycles.push_back(cyc);
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        rst   = 1'b1;
        u_if.run = 1'b1;
        u_if.din = 16'h2400;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        u_if.run = 1'b0;
        check_idle("reset_idle");

        // MVI R1, #0x00A5
        expect_out("mvi_t1", pk(BUS_DIN, 8'h02, 0, 0, 3'b000, 1, 0));
        send(16'h2400, 16'h00A5, 2);

        // ADD R2,R3
        expect_out("add_t1", pk(4'd2, 8'h00, 1, 0, 3'b000, 0, 0));
        expect_out("add_t2", pk(4'd3, 8'h00, 0, 1, 3'b010, 0, 0));
        expect_out("add_t3", pk(BUS_G, 8'h04, 0, 0, 3'b000, 1, 0));
        send(16'h4980, 16'h0000, 4);

        // Illegal opcodes 111 and 110
        expect_out("illegal_e000", pk(4'd0, 8'h00, 0, 0, 3'b000, 1, 1));
        send(16'hE000, 16'h0000, 2);
        expect_out("illegal_c000", pk(4'd0, 8'h00, 0, 0, 3'b000, 1, 1));
        send(16'hC000, 16'h0000, 2);

        // MV R7,R5
        expect_out("mv_r7_r5", pk(4'd5, 8'h80, 0, 0, 3'b000, 1, 0));
        send(16'h1E80, 16'h0000, 2);

        // XOR R0,R1 aborted by reset at the edge ending T1
        expect_out("xor_t1", pk(4'd0, 8'h00, 1, 0, 3'b000, 0, 0));
        @(posedge clk); #1;
        u_if.run = 1'b1;
        u_if.din = 16'h6080;
        @(posedge clk); #1;
        u_if.run = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle("abort_idle");
        repeat (3) @(posedge clk);

        // MV R4,R0 after the abort
        expect_out("mv_r4_r0", pk(4'd0, 8'h10, 0, 0, 3'b000, 1, 0));
        send(16'h1000, 16'h0000, 2);

        // ADD R3,R3
        expect_out("add33_t1", pk(4'd3, 8'h00, 1, 0, 3'b000, 0, 0));
        expect_out("add33_t2", pk(4'd3, 8'h00, 0, 1, 3'b010, 0, 0));
        expect_out("add33_t3", pk(BUS_G, 8'h08, 0, 0, 3'b000, 1, 0));
        send(16'h4D80, 16'h0000, 4);

        // Back-to-back AND R5,R6 then OR R7,R0 with run held high
        done_cycles.delete();
        expect_out("and_t1", pk(4'd5, 8'h00, 1, 0, 3'b000, 0, 0));
        expect_out("and_t2", pk(4'd6, 8'h00, 0, 1, 3'b101, 0, 0));
        expect_out("and_t3", pk(BUS_G, 8'h20, 0, 0, 3'b000, 1, 0));
        expect_out("or_t1",  pk(4'd7, 8'h00, 1, 0, 3'b000, 0, 0));
        expect_out("or_t2",  pk(4'd0, 8'h00, 0, 1, 3'b100, 0, 0));
        expect_out("or_t3",  pk(BUS_G, 8'h80, 0, 0, 3'b000, 1, 0));
        @(posedge clk); #1;
        u_if.run = 1'b1;
        u_if.din = 16'hB700;
        @(posedge clk); #1;
        u_if.din = 16'h9C00;
        repeat (4) @(posedge clk);
        #1;
        u_if.run = 1'b0;
        repeat (5) @(posedge clk);

        total++;
        if (done_cycles.size() != 2) begin
            bad++;
            $display("FAIL b2b_done_count got=%0d expected=2", done_cycles.size());
        end else if (done_cycles[1] - done_cycles[0] != 4) begin
            bad++;
            $display("FAIL b2b_done_spacing got=%0d expected=4", done_cycles[1] - done_cycles[0]);
        end

        check_idle("final_idle");

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expectations got=%0d expected=0 next=%s", exp_q.size(), name_q[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
